// File: rtl/speck_2ti_seq_ctrl_if.sv
// Host-side bus of the 2-share Speck sequencer: request handshake with
// plaintext/key shares in, result handshake with ciphertext shares out.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid and ready are both 1. The producer keeps valid and its data
// stable until that edge. The consumer may raise or lower ready freely.
interface speck_2ti_seq_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] pt_a;
    logic [127:0] pt_b;
    logic [127:0] key_a;
    logic [127:0] key_b;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ct_a;
    logic [127:0] ct_b;

    // Host side: issues requests and consumes results
    modport master (
        output in_valid, pt_a, pt_b, key_a, key_b, out_ready,
        input  in_ready, out_valid, ct_a, ct_b
    );

    // Sequencer side
    modport slave (
        input  in_valid, pt_a, pt_b, key_a, key_b, out_ready,
        output in_ready, out_valid, ct_a, ct_b
    );
endinterface

// File: rtl/speck_2ti_seq_ctrl.sv
// Sequencer for a bit-serial, two-share Speck128/128 core.
// Latches one request, streams the shares into the core LSB first, lets the
// core run, collects the 64 serial ciphertext bit pairs and holds the result
// until the host takes it. A watchdog aborts a core that never finishes.
module speck_2ti_seq_ctrl #(
    parameter int WDOG_LIMIT = 2100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    speck_2ti_seq_ctrl_if.slave   host,
    input  logic                  rnd_in,
    output logic                  busy,
    output logic                  wdog_err,
    output logic                  core_data_ina,
    output logic                  core_data_inb,
    output logic                  core_k_data_ina,
    output logic                  core_k_data_inb,
    output logic                  core_carry_init_a,
    output logic                  core_carry_init_b,
    output logic                  core_we,
    output logic                  core_start,
    input  logic [1:0]            core_cipher_out1,
    input  logic [1:0]            core_cipher_out2,
    input  logic                  core_rndlessthan32,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_UNLOAD = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam int RUN_W = $clog2(WDOG_LIMIT + 1);

    state_t           state_q;
    state_t           state_d;
    logic [6:0]       load_cnt;
    logic [RUN_W-1:0] run_cnt;
    logic [5:0]       cap_cnt;
    logic [127:0]     pt_a_q;
    logic [127:0]     pt_b_q;
    logic [127:0]     key_a_q;
    logic [127:0]     key_b_q;
    logic [127:0]     ct_a_q;
    logic [127:0]     ct_b_q;
    logic             rnd_q;
    logic             in_ready;
    logic             out_valid;
    logic             accept;
    logic             capture;
    logic             load_last;
    logic             wdog_hit;

    // A capture is any edge in the unload window where the core reports its
    // rounds are over; each one delivers one X bit and one Y bit per share.
    assign accept    = (state_q == S_IDLE) && host.in_valid;
    assign capture   = ((state_q == S_RUN) || (state_q == S_UNLOAD)) && !core_rndlessthan32;
    assign load_last = (load_cnt == 7'd127);
    assign wdog_hit  = (state_q == S_RUN) && core_rndlessthan32
                       && (run_cnt == RUN_W'(WDOG_LIMIT - 1));

    // Next-state and per-state control outputs
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        wdog_err   = 1'b0;
        core_we    = 1'b0;
        core_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (host.in_valid) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                core_we = 1'b1;
                if (load_last) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                core_start = 1'b1;
                if (capture) begin
                    state_d = S_UNLOAD;
                end else if (wdog_hit) begin
                    state_d = S_ERR;
                end
            end
            S_UNLOAD: begin
                core_start = 1'b1;
                if (capture && (cap_cnt == 6'd63)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (host.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                wdog_err = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any transaction at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Load, run and capture counters; each is zero outside its own phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt <= '0;
            run_cnt  <= '0;
            cap_cnt  <= '0;
        end else begin
            load_cnt <= (state_q == S_LOAD) ? load_cnt + 7'd1 : 7'd0;
            run_cnt  <= (state_q == S_RUN) ? run_cnt + RUN_W'(1) : '0;
            if (state_q == S_IDLE) begin
                cap_cnt <= '0;
            end else if (capture) begin
                cap_cnt <= cap_cnt + 6'd1;
            end
        end
    end

    // Share latches; written only on the accept edge so later in_valid
    // activity cannot disturb a transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pt_a_q  <= '0;
            pt_b_q  <= '0;
            key_a_q <= '0;
            key_b_q <= '0;
        end else if (accept) begin
            pt_a_q  <= host.pt_a;
            pt_b_q  <= host.pt_b;
            key_a_q <= host.key_a;
            key_b_q <= host.key_b;
        end
    end

    // Ciphertext assembly: capture k fills bit k of the Y word and bit k of
    // the X word of each share
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ct_a_q <= '0;
            ct_b_q <= '0;
        end else if (capture) begin
            ct_a_q[{1'b1, cap_cnt}] <= core_cipher_out1[1];
            ct_a_q[{1'b0, cap_cnt}] <= core_cipher_out1[0];
            ct_b_q[{1'b1, cap_cnt}] <= core_cipher_out2[1];
            ct_b_q[{1'b0, cap_cnt}] <= core_cipher_out2[0];
        end
    end

    // Fresh random bit for the carry-init sharing, refreshed every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_q <= 1'b0;
        end else begin
            rnd_q <= rnd_in;
        end
    end

    // Both carry-init shares carry the same bit, so the shared carry is 0
    // while each individual share line still looks random
    assign core_carry_init_a = rnd_q;
    assign core_carry_init_b = rnd_q;

    // Serial share feed, LSB first, only while loading
    assign core_data_ina   = (state_q == S_LOAD) ? pt_a_q[load_cnt]  : 1'b0;
    assign core_data_inb   = (state_q == S_LOAD) ? pt_b_q[load_cnt]  : 1'b0;
    assign core_k_data_ina = (state_q == S_LOAD) ? key_a_q[load_cnt] : 1'b0;
    assign core_k_data_inb = (state_q == S_LOAD) ? key_b_q[load_cnt] : 1'b0;

    assign host.in_ready  = in_ready;
    assign host.out_valid = out_valid;
    assign host.ct_a      = ct_a_q;
    assign host.ct_b      = ct_b_q;
    assign dbg_state      = state_q;

endmodule

// File: doc/speck_2ti_seq_ctrl.md
SPECK_2TI_SEQ_CTRL -- requirements
Module: speck_2ti_seq_ctrl

Interface
REQ-001 SHALL have parameter WDOG_LIMIT, default 2100: maximum RUN-state cycles before the watchdog fires.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid / in_ready  input / output  1 / 1  host request handshake.
REQ-005 pt_a, pt_b  input  128 / 128  plaintext shares; pt = pt_a^pt_b, [127:64]=X word, [63:0]=Y word.
REQ-006 key_a, key_b  input  128 / 128  key shares, same packing as the plaintext shares.
REQ-007 rnd_in  input  1  fresh random bit for the carry-init sharing.
REQ-008 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-009 ct_a, ct_b  output  128 / 128  ciphertext shares, same packing as the plaintext shares.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 wdog_err  output  1  one-cycle pulse when the watchdog fires.
REQ-012 core_data_ina, core_data_inb, core_k_data_ina, core_k_data_inb  output  1 each  serial share inputs to the 2-share core.
REQ-013 core_carry_init_a, core_carry_init_b  output  1 each  carry-init shares.
REQ-014 core_we, core_start  output  1 each  core load enable and run/sync-clear.
REQ-015 core_cipher_out1, core_cipher_out2  input  2 each  core outputs; bit[1]=X bit, bit[0]=Y bit.
REQ-016 core_rndlessthan32  input  1  core round-active flag.

Function
REQ-017 SHALL implement the FSM IDLE -> LOAD -> RUN -> UNLOAD -> DONE -> IDLE, plus a one-cycle ERR state.
REQ-018 IDLE: in_ready=1, core_we=0, core_start=0; an edge with in_valid&in_ready latches all four 128-bit shares and enters LOAD.
REQ-019 LOAD lasts exactly 128 cycles with core_we=1 and core_start=0.
REQ-020 LOAD cycle i (0..127) SHALL drive core_data_ina=pt_a[i], core_data_inb=pt_b[i], core_k_data_ina=key_a[i], core_k_data_inb=key_b[i] (LSB first).
REQ-021 core_carry_init_a and core_carry_init_b SHALL both equal a register loaded from rnd_in every cycle, so their XOR is always 0.
REQ-022 RUN: core_start=1, core_we=0; an internal counter increments every cycle.
REQ-023 Capture rule: on every edge in RUN or UNLOAD where core_rndlessthan32=0, capture capture index k (0..63):
- ct_a[64+k]=core_cipher_out1[1], ct_a[k]=core_cipher_out1[0];
- ct_b[64+k]=core_cipher_out2[1], ct_b[k]=core_cipher_out2[0].
REQ-024 The first capture SHALL move RUN to UNLOAD; k increments once per capture.
REQ-025 UNLOAD holds core_start=1; after the capture with k=63, the FSM enters DONE.
REQ-026 DONE: core_start=0, out_valid=1; ct_a/ct_b stay stable until an edge with out_valid&out_ready, which returns the FSM to IDLE.
REQ-027 in_valid SHALL be ignored outside IDLE: in_ready=0 and the latched shares do not change.
REQ-028 If the RUN counter reaches WDOG_LIMIT with core_rndlessthan32 still 1, the FSM enters ERR for one cycle:
- wdog_err=1, core_start=0, no out_valid;
- then returns to IDLE.
REQ-029 Nominal latency from the accept edge to out_valid rising is 1+128+2048+64 cycles, with 4 cycles of slack allowed.

Reset
REQ-030 While rst_n=0, the FSM is IDLE and all counters are 0.
REQ-031 During and after reset until the next accept: in_ready=1; out_valid, busy, wdog_err, core_we and core_start are 0; all core_* data outputs are 0; ct_a=ct_b=0.
REQ-032 Reset asserted mid-LOAD, RUN or UNLOAD SHALL abort immediately: no out_valid, core_start=0 asynchronously.

Verification
REQ-033 Speck128/128 known answer, core attached:
- key 0f0e0d0c0b0a0908_0706050403020100, pt 6c61766975716520_7469206564616d20;
- shares: pt_b=key_b=random, pt_a=pt^pt_b, key_a=key^key_b;
- required: ct_a^ct_b = a65d985179783265_7860fedf5c570d18, out_valid within 2245 cycles of accept.
REQ-034 Load-order check: pt_a=1, all other shares 0 -> core_data_ina=1 only on LOAD cycle 0, core_we high for exactly 128 cycles.
REQ-035 Back-pressure: out_ready held 0 for 50 cycles -> out_valid stays 1, ct stable, in_ready=0; release -> IDLE next cycle.
REQ-036 Watchdog: stub core with core_rndlessthan32 tied 1 -> wdog_err pulses exactly once after WDOG_LIMIT RUN cycles, then in_ready=1.
REQ-037 Reset mid-RUN (cycle 1000): busy=0 and core_start=0 immediately; a new request afterwards still produces the REQ-033 result.
REQ-038 Over every run, core_carry_init_a^core_carry_init_b=0 on every cycle, for arbitrary rnd_in.
